// File: rtl/result_drain_requant.sv
// Drains one 4x4 accumulator tile as a beat stream,
// optionally transposed, requantized to OUT_W-bit signed.
module result_drain_requant #(
  parameter int ACCUMULATE = 32,
  parameter int OUT_W      = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [15:0][ACCUMULATE-1:0]       tile_in,
  input  logic                              load,
  input  logic                              transpose,
  input  logic [4:0]                        shift,
  output logic                              load_ready,
  output logic [OUT_W-1:0]                  out_data,
  output logic [3:0]                        out_index,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              sat_flag,
  output logic                              done
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam int XW = ACCUMULATE + 1;

  localparam logic signed [XW-1:0] MAXV =
    {{(XW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV =
    {{(XW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};

  state_t                        state_q, state_d;
  logic [15:0][ACCUMULATE-1:0]   snap_q, snap_d;
  logic                          trans_q, trans_d;
  logic [4:0]                    shift_q, shift_d;
  logic [3:0]                    k_q, k_d;
  logic [OUT_W-1:0]              data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          sat_q, sat_d;
  logic                          done_q, done_d;

  logic [3:0]                    kn;
  logic [3:0]                    sel;
  logic [ACCUMULATE-1:0]         src_v;
  logic [4:0]                    src_sh;
  logic [OUT_W-1:0]              q_data;
  logic                          q_sat;

  // Round-half-up arithmetic shift at one extra bit, then saturate.
  function automatic logic [OUT_W:0] requant(
    input logic [ACCUMULATE-1:0] v,
    input logic [4:0]            sh
  );
    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] rnd;
    logic signed [XW-1:0] t;
    ext = {v[ACCUMULATE-1], v};
    rnd = '0;
    if (sh != 5'd0)
      rnd = {{(XW-1){1'b0}}, 1'b1} << (sh - 5'd1);
    t = (ext + rnd) >>> sh;
    if (t > MAXV)
      requant = {1'b1, OMAX};
    else if (t < MINV)
      requant = {1'b1, OMIN};
    else
      requant = {1'b0, t[OUT_W-1:0]};
  endfunction

  // Pick the source word and shift for the beat about to be registered.
  always_comb begin
    kn  = k_q + 4'd1;
    sel = trans_q ? {kn[1:0], kn[3:2]} : kn;
    if (state_q == IDLE) begin
      src_v  = tile_in[0];
      src_sh = shift;
    end else begin
      src_v  = snap_q[sel];
      src_sh = shift_q;
    end
    {q_sat, q_data} = requant(src_v, src_sh);
  end

  // Next-state and beat sequencing.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    trans_d = trans_q;
    shift_d = shift_q;
    k_d     = k_q;
    data_d  = data_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          snap_d  = tile_in;
          trans_d = transpose;
          shift_d = shift;
          k_d     = 4'd0;
          data_d  = q_data;
          sat_d   = q_sat;
          valid_d = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && out_ready) begin
          if (k_q == 4'd15) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d    = kn;
            data_d = q_data;
            sat_d  = q_sat;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any tile in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      trans_q <= 1'b0;
      shift_q <= '0;
      k_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      trans_q <= trans_d;
      shift_q <= shift_d;
      k_q     <= k_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign out_data   = data_q;
  assign out_index  = k_q;
  assign out_valid  = valid_q;
  assign sat_flag   = sat_q;
  assign done       = done_q;

endmodule
